// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter.
// Holds FSM state, owner encoding and default timing constants.
package mem_arb_pkg;

    localparam int MEM_LAT_DEF    = 2;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data grants made while a fetch waits.
// Clear has priority over increment.
module arb_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam logic [3:0] LP_MAX = 4'(MAX);

    logic [3:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LP_MAX)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_at_max = (r_cnt == LP_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one fixed-latency port.
// Data wins in IDLE unless the fetch has been starved STARVE_MAX times.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        busy
);

    localparam logic [3:0] LP_WAIT_INIT = 4'(MEM_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    owner_t      r_owner;
    logic [29:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [3:0]  r_wait;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    logic w_idle;
    logic w_at_max;
    logic w_force_if;
    logic w_grant_d;
    logic w_grant_if;
    logic w_starve_inc;
    logic w_starve_clr;
    logic w_unused_addr;

    assign w_unused_addr = ^{if_addr[1:0], d_addr[1:0]};

    assign w_idle       = (r_state == IDLE);
    assign w_force_if   = w_at_max & if_req;
    assign w_grant_d    = w_idle & d_req & ~w_force_if;
    assign w_grant_if   = w_idle & if_req & ~w_grant_d;
    assign w_starve_inc = w_grant_d & if_req;
    assign w_starve_clr = w_grant_if | (w_idle & ~if_req);

    arb_starve_cnt #(
        .MAX(STARVE_MAX)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .i_inc    (w_starve_inc),
        .i_clr    (w_starve_clr),
        .o_at_max (w_at_max)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_grant_d | w_grant_if) w_next = ACCESS;
            ACCESS:  w_next = r_we ? RESP : WAIT;
            WAIT:    if (r_wait == '0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner    <= OWN_NONE;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_wait     <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_grant_d) begin
                r_owner <= OWN_D;
                r_addr  <= d_addr[31:2];
                r_we    <= d_we;
                r_wdata <= d_wdata;
                // Store acks must present zero read data
                if (d_we) r_d_rdata <= '0;
            end else if (w_grant_if) begin
                r_owner <= OWN_IF;
                r_addr  <= if_addr[31:2];
                r_we    <= 1'b0;
                r_wdata <= '0;
            end
            if (r_state == ACCESS) begin
                r_wait <= LP_WAIT_INIT;
            end
            if (r_state == WAIT) begin
                if (r_wait == '0) begin
                    if (r_owner == OWN_D) r_d_rdata <= mem_rdata;
                    else r_if_rdata <= mem_rdata;
                end else begin
                    r_wait <= r_wait - 4'd1;
                end
            end
            if (r_state == RESP) begin
                r_owner <= OWN_NONE;
            end
        end
    end

    assign mem_en    = (r_state == ACCESS);
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_ack    = (r_state == RESP) && (r_owner == OWN_IF);
    assign d_ack     = (r_state == RESP) && (r_owner == OWN_D);
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign stall_if  = if_req & ~if_ack;
    assign busy      = ~w_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for the unified memory port arbiter.
// Random phase is checked against a transaction-level schedule model.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        busy;

    mem_port_arbiter #(
        .MEM_LAT    (LAT),
        .STARVE_MAX (SMAX)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] hashf(input logic [7:0] a);
        if (a == 8'd4) return 32'h8C220004;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    // Memory: data valid only in the cycle MEM_LAT after mem_en
    bit          tb_wr [256];
    logic [31:0] tb_mem[256];
    logic [7:0]  pend_addr;
    int          pend_cnt;

    always @(posedge clock) begin
        if (mem_en && mem_we) begin
            tb_mem[mem_addr[7:0]] <= mem_wdata;
            tb_wr[mem_addr[7:0]]  <= 1'b1;
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_cnt  <= 0;
            pend_addr <= '0;
        end else if (mem_en && !mem_we) begin
            pend_addr <= mem_addr[7:0];
            pend_cnt  <= LAT;
        end else if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
        end
    end

    always_comb begin
        mem_rdata = 32'hBAD0BAD0;
        if (pend_cnt == 1) begin
            mem_rdata = tb_wr[pend_addr] ? tb_mem[pend_addr] : hashf(pend_addr);
        end
    end

    bit          ref_wr [256];
    logic [31:0] ref_mem[256];

    function automatic logic [31:0] ref_rd(input logic [7:0] a);
        return ref_wr[a] ? ref_mem[a] : hashf(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input bit want_d, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(want_d ? d_ack : if_ack) && n < limit);
        chk(want_d ? "d_ack_seen" : "if_ack_seen",
            {31'b0, want_d ? d_ack : if_ack}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // Model state for the randomized phase
    bit          m_act;
    bit          m_d;
    bit          m_we;
    int          m_grant;
    int          m_ack;
    int          m_starve;
    logic [29:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    initial begin
        int r0, n, t_d, t_i, t_en, a0;
        int seq[$];
        int exp_seq[6];
        exp_seq = '{1, 1, 1, 1, 0, 1};

        repeat (3) @(negedge clock);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_mem_en", {31'b0, mem_en}, 0);
        chk("rst_if_ack", {31'b0, if_ack}, 0);
        chk("rst_d_ack", {31'b0, d_ack}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_addr", {2'b0, mem_addr}, 0);
        reset = 1'b0;
        @(negedge clock);

        // Single fetch
        if_req = 1'b1; if_addr = 32'h10; r0 = cyc;
        #1 chk("f_stall", {31'b0, stall_if}, 1);
        @(negedge clock);
        chk("f_mem_en", {31'b0, mem_en}, 1);
        chk("f_mem_addr", {2'b0, mem_addr}, 32'h4);
        chk("f_mem_we", {31'b0, mem_we}, 0);
        wait_ack(1'b0, 20, n);
        chk("f_latency", cyc - r0, LAT + 2);
        chk("f_rdata", if_rdata, 32'h8C220004);
        chk("f_stall_ack", {31'b0, stall_if}, 0);
        if_req = 1'b0;
        @(negedge clock);
        chk("f_idle", {31'b0, busy}, 0);

        // Store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100C; d_wdata = 32'hDEADBEEF;
        ref_wr[8'h03] = 1'b1; ref_mem[8'h03] = 32'hDEADBEEF; r0 = cyc;
        @(negedge clock);
        chk("s_mem_en", {31'b0, mem_en}, 1);
        chk("s_mem_we", {31'b0, mem_we}, 1);
        chk("s_mem_addr", {2'b0, mem_addr}, 32'h403);
        chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
        wait_ack(1'b1, 20, n);
        chk("s_latency", cyc - r0, 2);
        chk("s_rdata", d_rdata, 0);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clock);

        // Collision
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_addr = 32'h20;
        t_d = -1; t_i = -1;
        for (int i = 0; i < 30 && t_i < 0; i++) begin
            @(negedge clock);
            chk("c_excl", {31'b0, if_ack & d_ack}, 0);
            if (!if_ack) chk("c_stall", {31'b0, stall_if}, 1);
            if (d_ack && t_d < 0) begin
                t_d = cyc;
                chk("c_d_rdata", d_rdata, ref_rd(8'h08));
                d_req = 1'b0;
            end
            if (if_ack) begin
                t_i = cyc;
                chk("c_if_rdata", if_rdata, ref_rd(8'h10));
                if_req = 1'b0;
            end
        end
        chk("c_d_first", {31'b0, t_d >= 0 && t_i > t_d}, 1);
        chk("c_gap", t_i - t_d, 5);
        @(negedge clock);

        // Starvation
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_addr = 32'h30;
        for (int i = 0; i < 200 && seq.size() < 6; i++) begin
            @(negedge clock);
            if (d_ack) begin
                seq.push_back(1);
                d_addr = d_addr + 32'h4;
                if (seq.size() == 6) d_req = 1'b0;
            end
            if (if_ack) begin
                seq.push_back(0);
                if_req = 1'b0;
            end
        end
        chk("sv_count", seq.size(), 6);
        for (int i = 0; i < 6 && i < seq.size(); i++) begin
            chk($sformatf("sv_order%0d", i), seq[i], exp_seq[i]);
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (LAT + 4) @(negedge clock);

        // Reset in the first WAIT cycle
        if_req = 1'b1; if_addr = 32'h14;
        @(negedge clock);
        chk("r_mem_en", {31'b0, mem_en}, 1);
        @(negedge clock);
        chk("r_busy_wait", {31'b0, busy}, 1);
        reset = 1'b1;
        #1;
        chk("r_busy", {31'b0, busy}, 0);
        chk("r_mem_en0", {31'b0, mem_en}, 0);
        chk("r_no_ack", {31'b0, if_ack}, 0);
        @(negedge clock);
        chk("r_no_ack2", {31'b0, if_ack}, 0);
        chk("r_stall", {31'b0, stall_if}, 1);
        reset = 1'b0; r0 = cyc;
        wait_ack(1'b0, 20, n);
        chk("r_latency", cyc - r0, LAT + 2);
        chk("r_rdata", if_rdata, ref_rd(8'h05));
        if_req = 1'b0;
        @(negedge clock);

        // Back-to-back loads
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
        wait_ack(1'b1, 20, n);
        chk("b_rdata0", d_rdata, ref_rd(8'h00));
        a0 = cyc; d_addr = 32'h4;
        t_en = -1;
        for (int i = 0; i < 10 && t_en < 0; i++) begin
            @(negedge clock);
            if (mem_en) begin
                t_en = cyc;
                chk("b_addr1", {2'b0, mem_addr}, 32'h1);
            end
        end
        chk("b_gap", t_en - a0, 2);
        wait_ack(1'b1, 20, n);
        chk("b_rdata1", d_rdata, ref_rd(8'h01));
        d_req = 1'b0;
        repeat (3) @(negedge clock);

        // Randomized traffic against the schedule model
        m_act = 1'b0; m_starve = 0;
        for (int it = 0; it < 800; it++) begin
            int k;
            bit live, e_en, e_busy, e_iack, e_dack, pick_d;
            @(negedge clock);
            k = cyc;
            live   = m_act && (k <= m_ack);
            e_en   = live && (k == m_grant + 1);
            e_busy = live && (k > m_grant);
            e_iack = live && !m_d && (k == m_ack);
            e_dack = live && m_d && (k == m_ack);

            if (if_req) begin
                if (e_iack) begin
                    if ($urandom_range(1) == 0) if_addr = $urandom & 32'h3FF;
                    else if_req = 1'b0;
                end else if (!(live && !m_d) && $urandom_range(15) == 0) begin
                    if_req = 1'b0;
                end
            end else if ($urandom_range(2) == 0) begin
                if_req = 1'b1; if_addr = $urandom & 32'h3FF;
            end
            if (d_req) begin
                if (e_dack) begin
                    if ($urandom_range(1) == 0) begin
                        d_we = 1'($urandom_range(1)); d_addr = $urandom & 32'h3FF;
                        d_wdata = $urandom;
                    end else begin
                        d_req = 1'b0;
                    end
                end else if (!(live && m_d) && $urandom_range(15) == 0) begin
                    d_req = 1'b0;
                end
            end else if ($urandom_range(2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(1));
                d_addr = $urandom & 32'h3FF; d_wdata = $urandom;
            end
            #1;
            chk("x_if_ack", {31'b0, if_ack}, {31'b0, e_iack});
            chk("x_d_ack", {31'b0, d_ack}, {31'b0, e_dack});
            chk("x_mem_en", {31'b0, mem_en}, {31'b0, e_en});
            chk("x_busy", {31'b0, busy}, {31'b0, e_busy});
            chk("x_stall", {31'b0, stall_if}, {31'b0, if_req & ~e_iack});
            if (e_iack) chk("x_if_rdata", if_rdata, m_rdata);
            if (e_dack) chk("x_d_rdata", d_rdata, m_rdata);
            if (e_en) begin
                chk("x_mem_addr", {2'b0, mem_addr}, {2'b0, m_addr});
                chk("x_mem_we", {31'b0, mem_we}, {31'b0, m_we});
                if (m_we) chk("x_mem_wdata", mem_wdata, m_wdata);
            end

            if (!live) begin
                if (!if_req) m_starve = 0;
                if (if_req || d_req) begin
                    pick_d = d_req && !(if_req && m_starve == SMAX);
                    m_d = pick_d;
                    if (pick_d) begin
                        m_addr = d_addr[31:2]; m_we = d_we; m_wdata = d_wdata;
                        if (if_req && m_starve < SMAX) m_starve++;
                    end else begin
                        m_addr = if_addr[31:2]; m_we = 1'b0; m_wdata = '0;
                        m_starve = 0;
                    end
                    m_rdata = m_we ? 32'h0 : ref_rd(m_addr[7:0]);
                    if (m_we) begin
                        ref_wr[m_addr[7:0]] = 1'b1;
                        ref_mem[m_addr[7:0]] = m_wdata;
                    end
                    m_act = 1'b1; m_grant = k;
                    m_ack = k + (m_we ? 2 : LAT + 2);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
